// File: rtl/isa_pkg.sv
// isa_pkg: shared opcodes, instruction field positions and issue-stage states
package isa_pkg;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 25;
  localparam int DST_HI = 24;
  localparam int DST_LO = 21;
  localparam int SRC_HI = 20;
  localparam int SRC_LO = 17;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam logic [6:0] OPC_MUL = 7'b0110011;
  localparam logic [6:0] OPC_MOV = 7'b0000001;
  localparam logic [6:0] OPC_ADD = 7'b0000010;
  localparam logic [6:0] OPC_SUB = 7'b0000011;
  localparam logic [31:0] NOP_INSTR = {5'b11001, 27'b0};
  typedef enum logic [1:0] {S_PASS, S_START, S_WAIT, S_UCODE} issue_state_e;
endpackage

// File: rtl/issue_slot.sv
// issue_slot: one-entry valid/data output register with load, consume and flush
module issue_slot #(
  parameter int W = 32,
  parameter logic [W-1:0] EMPTY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         consume,
  input  logic         flush,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);
  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;
  // flush beats load, load beats consume; an empty slot always shows EMPTY
  always_comb begin
    valid_d = flush ? 1'b0 : load ? 1'b1 : consume ? 1'b0 : valid_q;
    data_d  = flush ? EMPTY : load ? load_data : consume ? EMPTY : data_q;
  end
  // slot register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= EMPTY;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/ucode_issue_stage.sv
// ucode_issue_stage: forwards IF words to ID, expanding MULs into a microcode MOV/ADD/SUB stream
module ucode_issue_stage #(
  parameter logic [6:0]  MUL_OPCODE = isa_pkg::OPC_MUL,
  parameter logic [31:0] NOP_INSTR  = isa_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  input  logic        id_ready,
  output logic        start_mul,
  output logic [3:0]  mul_dest,
  output logic [3:0]  mul_source,
  output logic [15:0] mul_imm,
  input  logic        uc_busy,
  input  logic [31:0] uc_instr,
  output logic        uc_advance,
  output logic [15:0] mul_cnt
);
  import isa_pkg::*;
  issue_state_e state_d, state_q;
  logic        start_mul_d, start_mul_q;
  logic [3:0]  mul_dest_d, mul_dest_q;
  logic [3:0]  mul_source_d, mul_source_q;
  logic [15:0] mul_imm_d, mul_imm_q;
  logic [15:0] mul_cnt_d, mul_cnt_q;
  logic        slot_free, is_mul, mul_go, slot_load, slot_flush;
  logic [31:0] slot_data;
  assign slot_free  = !id_valid || id_ready;
  assign if_ready   = (state_q == S_PASS) && slot_free;
  assign uc_advance = (state_q == S_UCODE) && uc_busy && slot_free;
  assign is_mul     = if_instr[OPC_HI:OPC_LO] == MUL_OPCODE;
  assign mul_go     = if_valid && if_ready && is_mul && !flush;
  assign slot_flush = flush && (state_q == S_PASS);
  assign slot_load  = (if_valid && if_ready && !is_mul) || uc_advance;
  assign slot_data  = uc_advance ? uc_instr : if_instr;
  issue_slot #(.W(32), .EMPTY(NOP_INSTR)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .consume   (id_ready),
    .flush     (slot_flush),
    .load_data (slot_data),
    .valid     (id_valid),
    .data      (id_instr)
  );
  // sequence control: a MUL leaves PASS, and the sequence ends when the controller drops busy
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      S_PASS:  state_d = mul_go ? S_START : S_PASS;
      S_START: state_d = S_WAIT;
      S_WAIT:  state_d = uc_busy ? S_UCODE : S_WAIT;
      S_UCODE: begin
        state_d   = uc_busy ? S_UCODE : S_PASS;
        mul_cnt_d = uc_busy ? mul_cnt_q : mul_cnt_q + 16'd1;
      end
      default: state_d = S_PASS;
    endcase
  end
  // operands are captured only when a MUL is really taken, and held until the next one
  always_comb begin
    start_mul_d  = mul_go;
    mul_dest_d   = mul_go ? if_instr[DST_HI:DST_LO] : mul_dest_q;
    mul_source_d = mul_go ? if_instr[SRC_HI:SRC_LO] : mul_source_q;
    mul_imm_d    = mul_go ? if_instr[IMM_HI:IMM_LO] : mul_imm_q;
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_PASS;
      start_mul_q  <= 1'b0;
      mul_dest_q   <= '0;
      mul_source_q <= '0;
      mul_imm_q    <= '0;
      mul_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      start_mul_q  <= start_mul_d;
      mul_dest_q   <= mul_dest_d;
      mul_source_q <= mul_source_d;
      mul_imm_q    <= mul_imm_d;
      mul_cnt_q    <= mul_cnt_d;
    end
  end
  assign start_mul  = start_mul_q;
  assign mul_dest   = mul_dest_q;
  assign mul_source = mul_source_q;
  assign mul_imm    = mul_imm_q;
  assign mul_cnt    = mul_cnt_q;
endmodule

// File: tb/tb_ucode_issue_stage.sv
// tb_ucode_issue_stage: directed bench with a transaction-level model and microcode controller
module tb_ucode_issue_stage;
  localparam logic [31:0] NOP   = {5'b11001, 27'b0};
  localparam logic [6:0]  MULOP = 7'b0110011;
  localparam logic [31:0] A1    = {7'b0000010, 4'd1, 4'd2, 1'b0, 16'h0011};
  localparam logic [31:0] A2    = {7'b0000010, 4'd3, 4'd4, 1'b0, 16'h0022};
  localparam logic [31:0] A3    = {7'b0000011, 4'd5, 4'd6, 1'b0, 16'h0033};
  localparam logic [31:0] MUL1  = {7'b0110011, 4'd1, 4'd0, 1'b0, 16'd3};
  localparam logic [31:0] MUL2  = {7'b0110011, 4'd2, 4'd3, 1'b0, 16'd5};
  localparam logic [31:0] MUL3  = {7'b0110011, 4'd7, 4'd6, 1'b0, 16'd9};
  localparam logic [31:0] U0    = {7'b0000001, 4'd1, 4'd0, 1'b0, 16'd0};
  localparam logic [31:0] U1    = {7'b0000010, 4'd1, 4'd1, 1'b0, 16'd1};
  localparam logic [31:0] U2    = {7'b0000010, 4'd1, 4'd1, 1'b0, 16'd2};
  localparam logic [31:0] U3    = {7'b0000010, 4'd1, 4'd1, 1'b0, 16'd3};

  logic clk = 0, rst = 1, flush = 0, if_valid = 0, id_ready = 1, uc_busy = 0;
  logic [31:0] if_instr = 0, uc_instr = 0, id_instr;
  logic if_ready, id_valid, start_mul, uc_advance;
  logic [3:0] mul_dest, mul_source;
  logic [15:0] mul_imm, mul_cnt;

  int n_tests = 0, n_fail = 0, n_starts = 0, n_adv = 0;
  logic [31:0] got[$];
  logic [31:0] ctl_q[$];
  logic [31:0] prog [4] = '{U0, U1, U2, U3};
  logic s_start = 0, s_adv = 0, preload = 0;

  bit m_valid, m_seq, m_bseen, m_start;
  logic [31:0] m_word;
  logic [3:0] m_dest, m_src;
  logic [15:0] m_imm, m_cnt;
  bit e_ifr, e_adv, acc, ismul, go;

  ucode_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .id_valid(id_valid), .id_instr(id_instr), .id_ready(id_ready),
    .start_mul(start_mul), .mul_dest(mul_dest), .mul_source(mul_source), .mul_imm(mul_imm),
    .uc_busy(uc_busy), .uc_instr(uc_instr), .uc_advance(uc_advance), .mul_cnt(mul_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // model: the stage's observable contract, checked at every mid-cycle sample
  always @(negedge clk) begin
    if (rst) begin
      m_valid = 0; m_word = NOP; m_seq = 0; m_bseen = 0; m_start = 0;
      m_dest = 0; m_src = 0; m_imm = 0; m_cnt = 0; s_start = 0; s_adv = 0;
    end
    if (preload) m_cnt = 16'hFFFE;
    e_ifr = !m_seq && (!m_valid || id_ready);
    e_adv = m_seq && m_bseen && uc_busy && (!m_valid || id_ready);
    chk("if_ready", if_ready, e_ifr);
    chk("uc_advance", uc_advance, e_adv);
    chk("id_valid", id_valid, m_valid);
    chk("id_instr", id_instr, m_word);
    chk("start_mul", start_mul, m_start);
    chk("mul_dest", mul_dest, m_dest);
    chk("mul_source", mul_source, m_src);
    chk("mul_imm", mul_imm, m_imm);
    chk("mul_cnt", mul_cnt, m_cnt);
    if (!rst) begin
      s_start = start_mul;
      s_adv = uc_advance;
      n_starts += int'(start_mul);
      n_adv += int'(uc_advance);
      if (id_valid && id_ready) got.push_back(id_instr);
      acc = if_valid && e_ifr;
      ismul = if_instr[31:25] == MULOP;
      go = acc && ismul && !flush;
      if (go) begin
        m_dest = if_instr[24:21]; m_src = if_instr[20:17]; m_imm = if_instr[15:0];
      end
      if (!m_seq && flush) begin m_valid = 0; m_word = NOP; end
      else if (acc && !ismul) begin m_valid = 1; m_word = if_instr; end
      else if (e_adv) begin m_valid = 1; m_word = uc_instr; end
      else if (id_ready) begin m_valid = 0; m_word = NOP; end
      m_start = go;
      if (go) begin m_seq = 1; m_bseen = 0; end
      else if (m_seq && m_bseen && !uc_busy) begin m_seq = 0; m_cnt = m_cnt + 16'd1; end
      else if (m_seq && uc_busy) m_bseen = 1;
    end
  end

  // microcode controller: busy the cycle after start_mul, steps only on uc_advance
  always begin
    @(posedge clk); #2;
    if (rst) begin
      uc_busy = 0; uc_instr = 0; ctl_q.delete();
    end else begin
      if (s_adv && ctl_q.size() > 0) begin
        void'(ctl_q.pop_front());
        if (ctl_q.size() == 0) uc_busy = 0;
        else uc_instr = ctl_q[0];
      end
      if (s_start) begin
        for (int i = 0; i < 4; i++) ctl_q.push_back(prog[i]);
        uc_busy = 1;
        uc_instr = ctl_q[0];
      end
    end
  end

  task automatic at_edge();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    logic ok;
    if_valid = 1; if_instr = w;
    do begin
      @(negedge clk); ok = if_ready;
      at_edge(); n++;
    end while (!ok && n < 100);
    chk("send_timeout", ok, 1);
    if_valid = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    logic done;
    do begin
      @(negedge clk); #1; done = !m_seq && !uc_busy && !id_valid;
      at_edge(); n++;
    end while (!done && n < 300);
    chk("seq_timeout", done, 1);
  endtask

  task automatic wait_adv(input int a0, input int k);
    int n = 0;
    while (n_adv - a0 < k && n < 100) begin at_edge(); n++; end
    chk("adv_timeout", n_adv - a0 >= k, 1);
  endtask

  task automatic chk_prog(input string name, input int base);
    chk({name, "_len"}, got.size() - base, 4);
    for (int i = 0; i < 4; i++) chk(name, got[base+i], prog[i]);
  endtask

  initial begin
    int base, st0, a0;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int base, st0, a0;
    at_edge(); at_edge();
    #1 rst = 0;
    @(negedge clk); #1;
    chk("reset_if_ready", if_ready, 1);
    chk("reset_id_instr", id_instr, NOP);
    at_edge();
    // plain stream with latency-1 forwarding
    base = got.size();
    send(A1);
    @(negedge clk); #1;
    chk("lat_valid", id_valid, 1);
    chk("lat_instr", id_instr, A1);
    at_edge();
    send(A2); send(A3);
    at_edge(); at_edge();
    chk("plain_len", got.size() - base, 3);
    chk("plain0", got[base], A1);
    chk("plain1", got[base+1], A2);
    chk("plain2", got[base+2], A3);
    chk("plain_cnt", mul_cnt, 0);
    // MUL R1,R0,#3 expanded into MOV + 3 ADDs
    base = got.size(); st0 = n_starts;
    send(MUL1);
    wait_done();
    chk("mul_starts", n_starts - st0, 1);
    chk("mul_dest_lit", mul_dest, 1);
    chk("mul_src_lit", mul_source, 0);
    chk("mul_imm_lit", mul_imm, 3);
    chk_prog("mul_stream", base);
    chk("mul_cnt1", mul_cnt, 1);
    chk("mul_if_ready", if_ready, 1);
    // backpressure in the middle of the sequence
    base = got.size(); a0 = n_adv;
    send(MUL2);
    wait_adv(a0, 2);
    id_ready = 0; a0 = n_adv;
    at_edge(); at_edge(); at_edge();
    chk("bp_no_adv", n_adv - a0, 0);
    id_ready = 1;
    wait_done();
    chk_prog("bp_stream", base);
    chk("bp_cnt", mul_cnt, 2);
    chk("bp_dest", mul_dest, 2);
    // flush together with MUL acceptance drops it
    st0 = n_starts; base = got.size();
    flush = 1;
    send(MUL3);
    flush = 0;
    at_edge(); at_edge(); at_edge();
    chk("flmul_starts", n_starts - st0, 0);
    chk("flmul_ready", if_ready, 1);
    chk("flmul_cnt", mul_cnt, 2);
    chk("flmul_len", got.size() - base, 0);
    // flush during UCODE is ignored
    base = got.size(); a0 = n_adv;
    send(MUL1);
    wait_adv(a0, 1);
    flush = 1; at_edge(); flush = 0;
    wait_done();
    chk_prog("flu_stream", base);
    chk("flu_cnt", mul_cnt, 3);
    // reset in the middle of UCODE
    a0 = n_adv;
    send(MUL2);
    wait_adv(a0, 2);
    #1 rst = 1;
    #1;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_start", start_mul, 0);
    chk("rst_adv", uc_advance, 0);
    chk("rst_dest", mul_dest, 0);
    chk("rst_src", mul_source, 0);
    chk("rst_imm", mul_imm, 0);
    chk("rst_cnt", mul_cnt, 0);
    @(posedge clk); #3 rst = 0;
    @(negedge clk); #1;
    chk("rst_if_ready", if_ready, 1);
    at_edge();
    // counter wrap, starting from a preloaded 16'hFFFE
    dut.mul_cnt_q = 16'hFFFE;
    preload = 1;
    @(negedge clk); #1 preload = 0;
    at_edge();
    send(MUL1); wait_done();
    chk("wrap_ffff", mul_cnt, 16'hFFFF);
    send(MUL2); wait_done();
    chk("wrap_zero", mul_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
